// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end for a 4004-style CPU: 8-phase cycle counter,
// 12-bit PC, nibble assembly into OPR/OPA/operand and two-word fetch control.
module fetch_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rom_nibble,
    output logic [2:0]  cycle,
    output logic [11:0] pc,
    output logic [3:0]  opr,
    output logic [3:0]  opa,
    output logic [7:0]  operand,
    output logic        two_word,
    output logic        fetch2,
    output logic        instr_valid,
    input  logic        jump_en,
    input  logic [11:0] jump_addr
);

    localparam logic [0:0] ST_FETCH1 = 1'b0;
    localparam logic [0:0] ST_FETCH2 = 1'b1;

    logic [2:0]  r_cycle;
    logic [11:0] r_pc;
    logic [3:0]  r_opr;
    logic [3:0]  r_opa;
    logic [7:0]  r_operand;
    logic        r_two_word;
    logic        r_valid;
    logic [0:0]  r_state;

    logic        w_two_word_dec;
    logic [11:0] w_pc_inc;

    // Decoded while OPA is still on the bus (cycle 4), OPR already captured in cycle 3.
    assign w_two_word_dec = (r_opr == 4'h1) ||
                            ((r_opr == 4'h2) && (rom_nibble[0] == 1'b0)) ||
                            (r_opr == 4'h4) ||
                            (r_opr == 4'h5) ||
                            (r_opr == 4'h7);
    assign w_pc_inc = r_pc + 12'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle    <= 3'd0;
            r_pc       <= RESET_PC;
            r_opr      <= 4'h0;
            r_opa      <= 4'h0;
            r_operand  <= 8'h00;
            r_two_word <= 1'b0;
            r_valid    <= 1'b0;
            r_state    <= ST_FETCH1;
        end else begin
            r_cycle <= r_cycle + 3'd1;
            r_valid <= 1'b0;
            case (r_cycle)
                3'd3: begin
                    if (r_state == ST_FETCH1) begin
                        r_opr <= rom_nibble;
                    end else begin
                        r_operand[7:4] <= rom_nibble;
                    end
                end
                3'd4: begin
                    if (r_state == ST_FETCH1) begin
                        r_opa      <= rom_nibble;
                        r_two_word <= w_two_word_dec;
                        if (!w_two_word_dec) begin
                            r_operand <= 8'h00;
                            r_valid   <= 1'b1;
                        end
                    end else begin
                        r_operand[3:0] <= rom_nibble;
                        r_valid        <= 1'b1;
                    end
                end
                3'd7: begin
                    // A pending second word takes priority over any jump request.
                    if ((r_state == ST_FETCH1) && r_two_word) begin
                        r_state <= ST_FETCH2;
                        r_pc    <= w_pc_inc;
                    end else begin
                        r_state <= ST_FETCH1;
                        r_pc    <= jump_en ? jump_addr : w_pc_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cycle       = r_cycle;
    assign pc          = r_pc;
    assign opr         = r_opr;
    assign opa         = r_opa;
    assign operand     = r_operand;
    assign two_word    = r_two_word;
    assign fetch2      = (r_state == ST_FETCH2);
    assign instr_valid = r_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a ROM array and an instruction-level fetch model
// predict every phase, PC, valid strobe and assembled instruction.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  rom_nibble;
  logic [2:0]  cycle;
  logic [11:0] pc;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  operand;
  logic        two_word;
  logic        fetch2;
  logic        instr_valid;
  logic        jump_en;
  logic [11:0] jump_addr;

  fetch_sequencer #(.RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_nibble  (rom_nibble),
    .cycle       (cycle),
    .pc          (pc),
    .opr         (opr),
    .opa         (opa),
    .operand     (operand),
    .two_word    (two_word),
    .fetch2      (fetch2),
    .instr_valid (instr_valid),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  rom [0:4095];
  int          total;
  int          bad;

  // instruction-level model state
  logic [2:0]  m_phase;
  logic [11:0] m_pc;
  logic        m_f2;
  logic        m_two;
  logic [3:0]  m_opr;
  logic [3:0]  m_opa;
  logic [7:0]  m_operand;

  function automatic logic is_two(input logic [7:0] b);
    logic [3:0] hi;
    hi = b[7:4];
    return (hi == 4'h1) || ((hi == 4'h2) && (b[0] == 1'b0)) ||
           (hi == 4'h4) || (hi == 4'h5) || (hi == 4'h7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    jump_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      rom_nibble = 4'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_cycle", cycle, 0);
    chk("rst_pc", pc, 12'h000);
    chk("rst_opr", opr, 0);
    chk("rst_opa", opa, 0);
    chk("rst_operand", operand, 0);
    chk("rst_two_word", two_word, 0);
    chk("rst_fetch2", fetch2, 0);
    chk("rst_valid", instr_valid, 0);
    rst = 1'b0;
    m_phase = 3'd0;
    m_pc = 12'h000;
    m_f2 = 1'b0;
    m_two = 1'b0;
    m_opr = 4'h0;
    m_opa = 4'h0;
    m_operand = 8'h00;
  endtask

  // driver: one clock, ROM answers from the model's own address and phase
  task automatic tick(input logic jen, input logic [11:0] jaddr);
    logic [7:0] b;
    logic       exp_valid;
    b = rom[m_pc];
    if (m_phase == 3'd3) rom_nibble = b[7:4];
    else if (m_phase == 3'd4) rom_nibble = b[3:0];
    else rom_nibble = 4'($urandom);
    jump_en = jen;
    jump_addr = jaddr;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    if (m_phase == 3'd4) begin
      if (!m_f2) begin
        m_opr = b[7:4];
        m_opa = b[3:0];
        m_two = is_two(b);
        if (!m_two) begin
          m_operand = 8'h00;
          exp_valid = 1'b1;
        end
      end else begin
        m_operand = b;
        exp_valid = 1'b1;
      end
    end
    if (m_phase == 3'd7) begin
      if (!m_f2 && m_two) begin
        m_f2 = 1'b1;
        m_pc = m_pc + 12'd1;
      end else begin
        m_f2 = 1'b0;
        m_pc = jen ? jaddr : m_pc + 12'd1;
      end
    end
    m_phase = m_phase + 3'd1;
    chk("cycle", cycle, m_phase);
    chk("pc", pc, m_pc);
    chk("fetch2", fetch2, m_f2);
    chk("instr_valid", instr_valid, exp_valid);
    if (m_phase == 3'd5) chk("two_word", two_word, m_two);
    if (exp_valid) begin
      chk("opr", opr, m_opr);
      chk("opa", opa, m_opa);
      chk("operand", operand, m_operand);
    end
  endtask

  // one full instruction cycle; jump_en raised only in phase jphase (-1: never)
  task automatic run_instr(input int jphase, input logic [11:0] jaddr);
    for (int p = 0; p < 8; p++) tick(p == jphase, jaddr);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    rom_nibble = 4'h0;
    jump_en = 1'b0;
    jump_addr = 12'h000;

    // single-word stream
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h85; rom[2] = 8'h97; rom[3] = 8'h00;
    do_reset(2);
    for (int i = 0; i < 3; i++) run_instr(-1, 12'h000);
    chk("seq_pc_after_24", pc, 12'h003);
    chk("seq_last_opr", opr, 4'h9);
    chk("seq_last_opa", opa, 4'h7);

    // JUN 0x012 then a single-word opcode
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h12; rom[2] = 8'h85;
    do_reset(1);
    run_instr(-1, 12'h000);
    run_instr(-1, 12'h000);
    chk("jun_pc_after_16", pc, 12'h002);
    chk("jun_operand", operand, 8'h12);
    chk("jun_two_word", two_word, 1'b1);
    run_instr(-1, 12'h000);

    // FIM is two-word, SRC (odd OPA) is single-word
    clear_rom();
    rom[0] = 8'h20; rom[1] = 8'h12; rom[2] = 8'h21;
    do_reset(1);
    for (int i = 0; i < 3; i++) run_instr(-1, 12'h000);
    chk("src_two_word", two_word, 1'b0);

    // jump handling
    clear_rom();
    rom[12'h124] = 8'h40; rom[12'h125] = 8'h55;
    do_reset(1);
    run_instr(7, 12'h123);
    chk("jump_pc", pc, 12'h123);
    run_instr(6, 12'h300);
    chk("jump_c6_ignored", pc, 12'h124);
    run_instr(7, 12'h300);
    chk("jump_fetch1_2w_ignored", pc, 12'h125);
    run_instr(7, 12'hFFF);
    chk("jump_fff", pc, 12'hFFF);
    run_instr(-1, 12'h000);
    chk("pc_wrap", pc, 12'h000);

    // reset in the middle of a second-word fetch
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'h12; rom[2] = 8'hA3;
    do_reset(1);
    for (int i = 0; i < 12; i++) tick(1'b0, 12'h000);
    chk("mid_fetch2_before_rst", fetch2, 1'b1);
    do_reset(1);
    for (int i = 0; i < 3; i++) run_instr(-1, 12'h000);
    chk("refetch_pc", pc, 12'h003);

    // random ROM contents and random jump requests
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    do_reset(1);
    for (int i = 0; i < 800; i++) tick($urandom_range(0, 3) == 0, 12'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
